spi_frame_serializer: RTL and testbench

Downstream stage of the SPI capture block. It takes the parallel multi-channel frame (`dataOut`/`dataOutValid`) produced on the divided SPI clock, brings it into the board `clk` domain, and buffers complete frames in a small FIFO. It then emits them as a valid/ready stream with one channel word per beat, for the DSP/beamforming path. Frames that arrive while the FIFO is full are dropped and counted.

---
 rtl/spi_frame_serializer_if.sv | 38 +++
 rtl/spi_frame_serializer.sv | 172 +++++++++++++++++
 tb/tb_spi_frame_serializer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_serializer_if.sv
// spi_frame_serializer_if
//   Output stream bundle of the SPI frame serializer: one channel word per
//   beat with a valid/ready handshake.
//   Signals:
//     outValid   - beat valid (driven by the serializer)
//     outReady   - consumer ready (driven by the consumer)
//     outData    - channel word
//     outChannel - channel index of the current beat
//     outLast    - high on the beat for the last channel of a frame
//   Modports: master = serializer side, slave = consumer side.
interface spi_frame_serializer_if #(
  parameter int NUM_SLAVES = 5,
  parameter int NUM_BITS   = 12
);
  localparam int CH_W = $clog2(NUM_SLAVES);

  logic                outValid;
  logic                outReady;
  logic [NUM_BITS-1:0] outData;
  logic [CH_W-1:0]     outChannel;
  logic                outLast;

  modport master (
    output outValid,
    output outData,
    output outChannel,
    output outLast,
    input  outReady
  );

  modport slave (
    input  outValid,
    input  outData,
    input  outChannel,
    input  outLast,
    output outReady
  );
endinterface

// File: rtl/spi_frame_serializer.sv
// spi_frame_serializer
//   Brings parallel multi-channel frames from the divided SPI clock domain
//   into clk, buffers whole frames in a small FIFO and emits them as a
//   valid/ready stream, one channel word per beat. Frames arriving while the
//   FIFO is full are dropped and counted.
//   Ports:
//     clk         - board clock, the only clock of this block
//     rst         - asynchronous, active-low reset
//     frameValid  - frame strobe from the SPI block (asynchronous level)
//     frameData   - frame words, element i is channel i
//     stream      - output stream (spi_frame_serializer_if.master)
//     clearStatus - synchronous clear of overflow and dropCount
//     overflow    - sticky, set when a frame is dropped
//     dropCount   - saturating count of dropped frames
module spi_frame_serializer #(
  parameter int NUM_SLAVES = 5,
  parameter int NUM_BITS   = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 frameValid,
  input  logic [NUM_SLAVES-1:0][NUM_BITS-1:0]  frameData,
  spi_frame_serializer_if.master               stream,
  input  logic                                 clearStatus,
  output logic                                 overflow,
  output logic [CNT_WIDTH-1:0]                 dropCount
);
  localparam int CH_W  = $clog2(NUM_SLAVES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_SLAVES - 1);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;

  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic s1, s2, s3;
  logic cap;
  logic full, push, drop, pop;

  logic [NUM_SLAVES-1:0][NUM_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W:0]   count, countNext;

  state_t          state;
  logic [CH_W-1:0] chan;
  logic            outValidR;
  logic            outLastR;

  // Synchronizer stage: s1/s2 resolve metastability, s3 detects the rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= frameValid;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign cap = s2 & ~s3;

  // Fullness is judged on the registered count: a pop in the same cycle
  // does not make room for a capture.
  assign full = (count == DEPTH_C);
  assign push = cap & ~full;
  assign drop = cap & full;
  assign pop  = outValidR & stream.outReady & (chan == LAST_CH);

  always_comb begin
    countNext = count;
    case ({push, pop})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  // FIFO stage: frame storage carries no reset, only the pointers do.
  // frameData is stable at the capture edge by upstream guarantee.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= frameData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      count <= countNext;
    end
  end

  // Read FSM stage. Staying in STREAM after the last beat when another frame
  // is buffered (including one pushed on that same edge) avoids a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      chan      <= '0;
      outValidR <= 1'b0;
      outLastR  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= STREAM;
            chan      <= '0;
            outValidR <= 1'b1;
            outLastR  <= 1'b0;
          end
        end
        STREAM: begin
          if (stream.outReady) begin
            if (chan != LAST_CH) begin
              chan     <= chan + 1'b1;
              outLastR <= (chan + 1'b1 == LAST_CH);
            end else begin
              chan     <= '0;
              outLastR <= 1'b0;
              if (countNext == '0) begin
                state     <= IDLE;
                outValidR <= 1'b0;
              end
            end
          end
        end
        default: begin
          state     <= IDLE;
          chan      <= '0;
          outValidR <= 1'b0;
          outLastR  <= 1'b0;
        end
      endcase
    end
  end

  // Data is read straight from the registered head pointer and channel;
  // gating with outValidR makes it zero while idle and during reset.
  assign stream.outValid   = outValidR;
  assign stream.outData    = outValidR ? mem[rdPtr][chan] : '0;
  assign stream.outChannel = chan;
  assign stream.outLast    = outLastR;

  // Status stage: a drop wins over a coincident clear, restarting at one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      dropCount <= '0;
    end else if (drop) begin
      overflow  <= 1'b1;
      dropCount <= clearStatus ? CNT_WIDTH'(1) : satInc(dropCount);
    end else if (clearStatus) begin
      overflow  <= 1'b0;
      dropCount <= '0;
    end
  end
endmodule

// File: tb/tb_spi_frame_serializer.sv
module tb_spi_frame_serializer;
  localparam int NS = 5;
  localparam int NB = 12;
  localparam int FD = 4;
  localparam int CW = 2;

  logic                  clk;
  logic                  rst;
  logic                  frameValid;
  logic [NS-1:0][NB-1:0] frameData;
  logic                  clearStatus;
  logic                  overflow;
  logic [CW-1:0]         dropCount;

  spi_frame_serializer_if #(.NUM_SLAVES(NS), .NUM_BITS(NB)) sif ();

  spi_frame_serializer #(
    .NUM_SLAVES(NS),
    .NUM_BITS  (NB),
    .FIFO_DEPTH(FD),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frameValid (frameValid),
    .frameData  (frameData),
    .stream     (sif),
    .clearStatus(clearStatus),
    .overflow   (overflow),
    .dropCount  (dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        v;
    logic [2:0]  ch;
    logic [11:0] d;
    logic        l;
  } vec_t;

  vec_t singleTab[6];
  vec_t bpTab[15];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic v, input int ch, input int d, input logic l);
    vec_t x;
    x.rdy = r;
    x.v   = v;
    x.ch  = 3'(ch);
    x.d   = 12'(d);
    x.l   = l;
    return x;
  endfunction

  function automatic logic [NS-1:0][NB-1:0] mkFrame(input int base);
    logic [NS-1:0][NB-1:0] f;
    for (int i = 0; i < NS; i++) f[i] = 12'(base + i);
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chkBeat(input string tag, input int idx, input logic v, input int ch, input int d, input logic l);
    chk($sformatf("%s[%0d].valid", tag, idx), 32'(sif.outValid), 32'(v));
    chk($sformatf("%s[%0d].chan", tag, idx), 32'(sif.outChannel), 32'(ch));
    chk($sformatf("%s[%0d].data", tag, idx), 32'(sif.outData), 32'(d));
    chk($sformatf("%s[%0d].last", tag, idx), 32'(sif.outLast), 32'(l));
  endtask

  // Compare the current outputs, then drive ready for the coming edge.
  task automatic applyVec(input string tag, input int idx, input vec_t v);
    chkBeat(tag, idx, v.v, int'(v.ch), int'(v.d), v.l);
    sif.outReady = v.rdy;
    @(negedge clk);
  endtask

  task automatic sendFrame(input int base);
    frameData  = mkFrame(base);
    frameValid = 1'b1;
    repeat (4) @(negedge clk);
    frameValid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic doReset();
    rst          = 1'b0;
    clearStatus  = 1'b0;
    frameValid   = 1'b0;
    sif.outReady = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int idleBeats;

    for (int i = 0; i < NS; i++)
      singleTab[i] = mk(1'b1, 1'b1, i, 'h101 + i, i == NS - 1);
    singleTab[5] = mk(1'b1, 1'b0, 0, 0, 1'b0);
    bpTab[0] = mk(1'b1, 1'b1, 0, 'h101, 1'b0);
    for (int b = 1; b < NS; b++)
      for (int s = 0; s < 3; s++)
        bpTab[1 + 3 * (b - 1) + s] = mk(s == 2, 1'b1, b, 'h101 + b, b == NS - 1);
    bpTab[13] = mk(1'b1, 1'b0, 0, 0, 1'b0);
    bpTab[14] = mk(1'b0, 1'b0, 0, 0, 1'b0);

    rst          = 1'b0;
    frameValid   = 1'b0;
    frameData    = '0;
    clearStatus  = 1'b0;
    sif.outReady = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.valid", 32'(sif.outValid), 32'(0));
    chk("reset.data", 32'(sif.outData), 32'(0));
    chk("reset.last", 32'(sif.outLast), 32'(0));
    chk("reset.overflow", 32'(overflow), 32'(0));
    chk("reset.dropCount", 32'(dropCount), 32'(0));
    rst = 1'b1;
    @(negedge clk);

    // Single frame with latency check
    sif.outReady = 1'b1;
    frameData    = mkFrame('h101);
    frameValid   = 1'b1;
    repeat (3) @(negedge clk);
    chk("single.latency_edge2", 32'(sif.outValid), 32'(0));
    @(negedge clk);
    frameValid = 1'b0;
    for (int i = 0; i < 6; i++) applyVec("single", i, singleTab[i]);

    // Backpressure
    sif.outReady = 1'b0;
    frameValid   = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    frameValid = 1'b0;
    hs = 0;
    for (int i = 0; i < 15; i++) begin
      if (sif.outValid && bpTab[i].rdy) hs++;
      applyVec("bp", i, bpTab[i]);
    end
    chk("bp.handshakes", 32'(hs), 32'(5));

    // Overflow: 6 frames into a 4-deep FIFO while stalled
    doReset();
    for (int k = 1; k <= 6; k++) sendFrame(k * 'h100);
    chk("ovf.overflow", 32'(overflow), 32'(1));
    chk("ovf.dropCount", 32'(dropCount), 32'(2));
    sif.outReady = 1'b1;
    for (int b = 0; b < 20; b++) begin
      chkBeat("ovf.beat", b, 1'b1, b % NS, (b / NS + 1) * 'h100 + b % NS, (b % NS) == NS - 1);
      @(negedge clk);
    end
    chk("ovf.idle", 32'(sif.outValid), 32'(0));

    // Saturation and clear
    doReset();
    for (int k = 1; k <= 9; k++) sendFrame(k * 'h100);
    chk("sat.dropCount", 32'(dropCount), 32'(3));
    chk("sat.overflow", 32'(overflow), 32'(1));
    chk("sat.headData", 32'(sif.outData), 32'('h100));
    clearStatus = 1'b1;
    @(negedge clk);
    clearStatus = 1'b0;
    chk("clr.dropCount", 32'(dropCount), 32'(0));
    chk("clr.overflow", 32'(overflow), 32'(0));
    frameData  = mkFrame('hA00);
    frameValid = 1'b1;
    repeat (2) @(negedge clk);
    clearStatus = 1'b1;
    @(negedge clk);
    clearStatus = 1'b0;
    chk("clrDrop.dropCount", 32'(dropCount), 32'(1));
    chk("clrDrop.overflow", 32'(overflow), 32'(1));
    @(negedge clk);
    frameValid = 1'b0;
    repeat (4) @(negedge clk);

    // Push/pop at full: capture lands on the last-beat pop of frame 1
    frameData    = mkFrame('hB00);
    sif.outReady = 1'b1;
    repeat (2) @(negedge clk);
    frameValid = 1'b1;
    repeat (2) @(negedge clk);
    chk("pp.lastChan", 32'(sif.outChannel), 32'(4));
    chk("pp.lastFlag", 32'(sif.outLast), 32'(1));
    @(negedge clk);
    chk("pp.dropCount", 32'(dropCount), 32'(2));
    for (int b = 0; b < 15; b++) begin
      if (b == 1) frameValid = 1'b0;
      chkBeat("pp.beat", b, 1'b1, b % NS, (b / NS + 2) * 'h100 + b % NS, (b % NS) == NS - 1);
      @(negedge clk);
    end
    chk("pp.idle", 32'(sif.outValid), 32'(0));

    // Reset mid-stream with a second frame queued
    doReset();
    sendFrame('h101);
    sendFrame('h201);
    sif.outReady = 1'b1;
    chk("rstm.beat1", 32'(sif.outChannel), 32'(0));
    repeat (2) @(negedge clk);
    chk("rstm.beat3", 32'(sif.outChannel), 32'(2));
    rst = 1'b0;
    #1;
    chk("rstm.valid", 32'(sif.outValid), 32'(0));
    chk("rstm.data", 32'(sif.outData), 32'(0));
    chk("rstm.chan", 32'(sif.outChannel), 32'(0));
    chk("rstm.last", 32'(sif.outLast), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idleBeats = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sif.outValid) idleBeats++;
    end
    chk("rstm.noBeats", 32'(idleBeats), 32'(0));
    frameData  = mkFrame('hC01);
    frameValid = 1'b1;
    repeat (4) @(negedge clk);
    frameValid = 1'b0;
    for (int b = 0; b < NS; b++) begin
      chkBeat("rstm.new", b, 1'b1, b, 'hC01 + b, b == NS - 1);
      @(negedge clk);
    end
    chk("rstm.idle", 32'(sif.outValid), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
